iram_loader: RTL and testbench

Boot/debug loader that sequences writes into the instruction RAM from a byte stream, such as a UART receiver. It parses a framed image (magic, word count, little-endian data words, checksum) and issues one-cycle word writes on the instruction RAM write port. While a load is in progress, it holds the core off instruction fetch. It sits between the byte source and the instruction RAM write port; the core fetch path is untouched.

---
 rtl/iram_loader.sv | 173 +++++++++++++++++
 tb/tb_iram_loader.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
// iram_loader: framed byte-stream loader for the instruction RAM.
// Parses MAGIC/COUNT/data/CSUM and holds the core while a load runs.
module iram_loader #(
  parameter int         IRAM_DEPTH = 1024,
  parameter logic [7:0] MAGIC      = 8'hA5,
  parameter int         TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        iram_we,
  output logic [31:0] iram_waddr,
  output logic [31:0] iram_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] DEPTH = 32'(IRAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_n;

  logic          ready_q;
  logic          done_q;
  logic [15:0]   cnt;
  logic [15:0]   widx;
  logic [1:0]    lane;
  logic [23:0]   wbuf;
  logic [7:0]    sum;
  logic [IW-1:0] idle;

  logic        acc;
  logic        take;
  logic        in_frame;
  logic        tmo;
  logic        magic;
  logic        last;
  logic [15:0] count_n;

  assign acc      = byte_valid && ready_q;
  assign in_frame = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);
  // A timeout wins over a byte arriving on the same cycle.
  assign tmo      = in_frame && (idle == IW'(TIMEOUT));
  assign take     = acc && !tmo;
  assign magic    = (byte_data == MAGIC);
  assign count_n  = {byte_data, cnt[7:0]};
  assign last     = (widx == cnt - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (take && magic) state_n = S_LEN0;
      end
      S_LEN0: begin
        if (tmo) state_n = S_ERR;
        else if (take) state_n = S_LEN1;
      end
      S_LEN1: begin
        if (tmo) begin
          state_n = S_ERR;
        end else if (take) begin
          if ({16'd0, count_n} > DEPTH) state_n = S_ERR;
          else if (count_n == 16'd0) state_n = S_CSUM;
          else state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tmo) state_n = S_ERR;
        else if (take && lane == 2'd3 && last) state_n = S_CSUM;
      end
      S_CSUM: begin
        if (tmo) state_n = S_ERR;
        else if (take) state_n = (byte_data == sum) ? S_DONE : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    core_hold = 1'b0;
    load_err  = 1'b0;
    unique case (1'b1)
      in_frame: core_hold = 1'b1;
      state == S_ERR: begin
        core_hold = 1'b1;
        load_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_ready = ready_q;
  assign load_done  = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      iram_we    <= 1'b0;
      iram_waddr <= '0;
      iram_wdata <= '0;
      cnt        <= '0;
      widx       <= '0;
      lane       <= '0;
      wbuf       <= '0;
      sum        <= '0;
      idle       <= '0;
    end else begin
      ready_q <= 1'b1;
      iram_we <= 1'b0;
      done_q  <= 1'b0;
      if (!in_frame || acc) idle <= '0;
      else idle <= idle + IW'(1);
      if (take) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (magic) begin
              cnt  <= '0;
              widx <= '0;
              lane <= '0;
              wbuf <= '0;
              sum  <= '0;
            end
          end
          S_LEN0: cnt[7:0] <= byte_data;
          S_LEN1: cnt[15:8] <= byte_data;
          S_DATA: begin
            sum  <= sum + byte_data;
            lane <= lane + 2'd1;
            unique case (lane)
              2'd0: wbuf[7:0]   <= byte_data;
              2'd1: wbuf[15:8]  <= byte_data;
              2'd2: wbuf[23:16] <= byte_data;
              default: begin
                iram_we    <= 1'b1;
                iram_waddr <= {16'd0, widx};
                iram_wdata <= {byte_data, wbuf};
                widx       <= widx + 16'd1;
              end
            endcase
          end
          S_CSUM: done_q <= (byte_data == sum);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader: scenario tasks plus randomized frames checked
// against a frame-level model of the loader.
module tb_iram_loader;
  localparam int         DEPTH = 1024;
  localparam int         TMO   = 40;
  localparam logic [7:0] MG    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        iram_we;
  logic [31:0] iram_waddr;
  logic [31:0] iram_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  logic [7:0]  frame[$];
  logic [63:0] exp_w[$];
  logic [63:0] got_w[$];
  bit exp_ok;

  iram_loader #(
    .IRAM_DEPTH(DEPTH),
    .MAGIC(MG),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .iram_we(iram_we),
    .iram_waddr(iram_waddr),
    .iram_wdata(iram_wdata),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iram_we) got_w.push_back({iram_waddr, iram_wdata});
    if (load_done) done_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame-level model: derive expected writes and outcome from bytes.
  function automatic void model();
    int c;
    logic [7:0] s;
    exp_w.delete();
    exp_ok = 1'b0;
    c = int'({frame[2], frame[1]});
    if (c > DEPTH) return;
    s = 8'h00;
    for (int i = 0; i < c; i++) begin
      exp_w.push_back({32'(i), frame[3+4*i+3], frame[3+4*i+2],
                       frame[3+4*i+1], frame[3+4*i]});
      for (int k = 0; k < 4; k++) s = s + frame[3+4*i+k];
    end
    exp_ok = (frame[3+4*c] == s);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    foreach (frame[i]) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      send_byte(frame[i]);
    end
  endtask

  task automatic rand_frame(input int count, input bit corrupt);
    logic [7:0] s;
    logic [7:0] d;
    frame.delete();
    frame.push_back(MG);
    frame.push_back(8'(count));
    frame.push_back(8'(count >> 8));
    s = 8'h00;
    for (int i = 0; i < 4 * count; i++) begin
      d = 8'($urandom_range(255, 0));
      frame.push_back(d);
      s = s + d;
    end
    if (corrupt) s = s + 8'($urandom_range(255, 1));
    frame.push_back(s);
  endtask

  task automatic clear_obs();
    got_w.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    compared++;
    if ({byte_ready, iram_we, core_hold, load_done, load_err,
         iram_waddr, iram_wdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_outs: got %b/%b/%b/%b/%b %h %h expected all zero",
               byte_ready, iram_we, core_hold, load_done, load_err,
               iram_waddr, iram_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (byte_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b expected 1", byte_ready);
    end
  endtask

  task automatic test_good_frame();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    model();
    clear_obs();
    send_byte(frame[0]);
    compared++;
    if (core_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL good_hold_rise: got %b expected 1", core_hold);
    end
    for (int i = 1; i < 7; i++) send_byte(frame[i]);
    compared++;
    if ({iram_we, iram_waddr, iram_wdata} !== {1'b1, 32'd0, 32'h44332211}) begin
      mismatched++;
      $display("FAIL good_w0: got %b %h %h expected 1 0 44332211",
               iram_we, iram_waddr, iram_wdata);
    end
    for (int i = 7; i < 12; i++) send_byte(frame[i]);
    compared++;
    if ({load_done, core_hold} !== 2'b10) begin
      mismatched++;
      $display("FAIL good_done: got done=%b hold=%b expected 1 0",
               load_done, core_hold);
    end
    idle(3);
    compared++;
    if (got_w.size() !== exp_w.size()) begin
      mismatched++;
      $display("FAIL good_nwr: got %0d expected %0d", got_w.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      compared++;
      if (got_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL good_wr%0d: got %h expected %h", i, got_w[i], exp_w[i]);
      end
    end
    compared++;
    if ({done_cnt == 1, load_err, core_hold} !== 3'b100) begin
      mismatched++;
      $display("FAIL good_final: got done=%0d err=%b hold=%b expected 1 0 0",
               done_cnt, load_err, core_hold);
    end
  endtask

  task automatic test_bad_csum();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    model();
    clear_obs();
    send_frame(0);
    idle(3);
    compared++;
    if (got_w.size() !== exp_w.size()) begin
      mismatched++;
      $display("FAIL bad_nwr: got %0d expected %0d", got_w.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      compared++;
      if (got_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL bad_wr%0d: got %h expected %h", i, got_w[i], exp_w[i]);
      end
    end
    compared++;
    if ({done_cnt == 0, load_err, core_hold} !== {1'b1, !exp_ok, !exp_ok}) begin
      mismatched++;
      $display("FAIL bad_final: got done=%0d err=%b hold=%b expected 0 1 1",
               done_cnt, load_err, core_hold);
    end
    rand_frame(2, 1'b0);
    model();
    clear_obs();
    send_byte(frame[0]);
    compared++;
    if ({load_err, core_hold} !== 2'b01) begin
      mismatched++;
      $display("FAIL recover_clear: got err=%b hold=%b expected 0 1",
               load_err, core_hold);
    end
    for (int i = 1; i < frame.size(); i++) send_byte(frame[i]);
    idle(3);
    compared++;
    if ({got_w.size() == exp_w.size(), done_cnt == 1, load_err, core_hold}
        !== 4'b1100) begin
      mismatched++;
      $display("FAIL recover_final: got nwr=%0d done=%0d err=%b hold=%b expected %0d 1 0 0",
               got_w.size(), done_cnt, load_err, core_hold, exp_w.size());
    end
  endtask

  task automatic test_count_limit();
    frame = '{8'hA5, 8'h01, 8'h04};
    model();
    clear_obs();
    send_frame(0);
    compared++;
    if ({load_err, core_hold} !== {!exp_ok, 1'b1}) begin
      mismatched++;
      $display("FAIL limit_err: got err=%b hold=%b expected 1 1", load_err, core_hold);
    end
    idle(4);
    compared++;
    if (got_w.size() !== 0 || done_cnt !== 0) begin
      mismatched++;
      $display("FAIL limit_nwr: got nwr=%0d done=%0d expected 0 0",
               got_w.size(), done_cnt);
    end
  endtask

  task automatic test_zero_count();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model();
    clear_obs();
    send_frame(0);
    compared++;
    if ({load_done, load_err, core_hold} !== {exp_ok, 2'b00}) begin
      mismatched++;
      $display("FAIL zero_done: got done=%b err=%b hold=%b expected 1 0 0",
               load_done, load_err, core_hold);
    end
    idle(2);
    compared++;
    if (got_w.size() !== exp_w.size()) begin
      mismatched++;
      $display("FAIL zero_nwr: got %0d expected %0d", got_w.size(), exp_w.size());
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    idle(TMO - 2);
    compared++;
    if ({load_err, core_hold} !== 2'b01) begin
      mismatched++;
      $display("FAIL tmo_early: got err=%b hold=%b expected 0 1", load_err, core_hold);
    end
    idle(5);
    compared++;
    if ({load_err, core_hold} !== 2'b11) begin
      mismatched++;
      $display("FAIL tmo_err: got err=%b hold=%b expected 1 1", load_err, core_hold);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    idle(2);
    compared++;
    if ({got_w.size() == 0, load_err, core_hold} !== 3'b111) begin
      mismatched++;
      $display("FAIL tmo_after: got nwr=%0d err=%b hold=%b expected 0 1 1",
               got_w.size(), load_err, core_hold);
    end
  endtask

  task automatic test_garbage_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    clear_obs();
    frame = '{8'h00, 8'hFF, 8'h12};
    foreach (frame[i]) begin
      send_byte(frame[i]);
      compared++;
      if ({core_hold, load_err} !== 2'b00) begin
        mismatched++;
        $display("FAIL garbage_%0d: got hold=%b err=%b expected 0 0",
                 i, core_hold, load_err);
      end
    end
    frame = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(0);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({byte_ready, iram_we, core_hold, load_done, load_err,
         iram_waddr, iram_wdata} !== '0) begin
      mismatched++;
      $display("FAIL midrst_outs: got %b/%b/%b/%b/%b %h %h expected all zero",
               byte_ready, iram_we, core_hold, load_done, load_err,
               iram_waddr, iram_wdata);
    end
    idle(1);
    rst = 1'b0;
    idle(3);
    compared++;
    if (got_w.size() !== 1 || core_hold !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_nwr: got nwr=%0d hold=%b expected 1 0",
               got_w.size(), core_hold);
    end
    rand_frame(2, 1'b0);
    clear_obs();
    send_frame(0);
    idle(2);
    compared++;
    if ({done_cnt == 1, got_w.size() == 2, load_err} !== 3'b110) begin
      mismatched++;
      $display("FAIL midrst_idle: got done=%0d nwr=%0d err=%b expected 1 2 0",
               done_cnt, got_w.size(), load_err);
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 8; n++) begin
      rand_frame(int'($urandom_range(6, 1)), ($urandom_range(2, 0) == 0));
      model();
      clear_obs();
      send_frame(3);
      idle(3);
      compared++;
      if (got_w.size() !== exp_w.size()) begin
        mismatched++;
        $display("FAIL rnd%0d_nwr: got %0d expected %0d", n, got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
        compared++;
        if (got_w[i] !== exp_w[i]) begin
          mismatched++;
          $display("FAIL rnd%0d_wr%0d: got %h expected %h", n, i, got_w[i], exp_w[i]);
        end
      end
      compared++;
      if ({done_cnt == int'(exp_ok), load_err, core_hold}
          !== {1'b1, !exp_ok, !exp_ok}) begin
        mismatched++;
        $display("FAIL rnd%0d_final: got done=%0d err=%b hold=%b expected %0d %b %b",
                 n, done_cnt, load_err, core_hold, exp_ok, !exp_ok, !exp_ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    rand_frame(16, 1'b0);
    model();
    clear_obs();
    send_frame(0);
    idle(3);
    compared++;
    if (got_w.size() !== exp_w.size()) begin
      mismatched++;
      $display("FAIL b2b_nwr: got %0d expected %0d", got_w.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < got_w.size()) begin
      compared++;
      if (got_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL b2b_wr%0d: got %h expected %h", i, got_w[i], exp_w[i]);
      end
    end
    compared++;
    if ({done_cnt == 1, load_err, core_hold} !== 3'b100) begin
      mismatched++;
      $display("FAIL b2b_final: got done=%0d err=%b hold=%b expected 1 0 0",
               done_cnt, load_err, core_hold);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_count_limit();
    test_zero_count();
    test_timeout();
    test_garbage_reset();
    test_random_frames();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
